// File: rtl/shift_r_seq.sv
// shift_r_seq: multi-cycle right shifter (SRL/SRLI/SRA/SRAI) for the
// area-reduced execute-stage shifter.
// A request is taken in IDLE. SHIFT then moves the operand right one bit
// per clock, with zero fill or sign fill. DONE holds the result until the
// consumer takes it.
// Optional build macro SHIFT_R_RADIX2_EN: SHIFT moves two bits per clock
// while at least two remain, and one bit for an odd final step.
//
// Handshake semantics:
//   - A request transfers on a rising edge where valid_i && ready_o && !flush_i.
//     ready_o is high only in IDLE.
//   - A result transfers on a rising edge where result_valid_o && result_ready_i.
//     result_o and result_valid_o hold stable until that edge.
//   - flush_i wins over every transition and returns the block to IDLE. It
//     leaves the data register and counter untouched.
// The FSM state is visible as state_q.
module shift_r_seq #(
   parameter int N       = 32,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [N-1:0]       data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic               arith_i,
   input  logic               flush_i,
   output logic [N-1:0]       result_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N-1:0]       data_q, data_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               arith_q, arith_d;
   logic               fill;

   // Fill bit for vacated positions: the sign bit when arithmetic, else zero.
   assign fill = arith_q & data_q[N-1];

   // Next-state and datapath update for the shift sequencer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  data_d  = data_i;
                  cnt_d   = shamt_i;
                  arith_d = arith_i;
                  state_d = (shamt_i == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
`ifdef SHIFT_R_RADIX2_EN
               // The counter is zero-extended so that the compare against 2
               // stays meaningful when SHAMT_W is 1.
               if ({1'b0, cnt_q} >= (SHAMT_W + 1)'(2)) begin
                  data_d = (data_q >> 2) | ({N{fill}} & ~({N{1'b1}} >> 2));
                  cnt_d  = cnt_q - SHAMT_W'(2);
               end else begin
                  data_d = {fill, data_q[N-1:1]};
                  cnt_d  = cnt_q - SHAMT_W'(1);
               end
               if (cnt_d == '0) begin
                  state_d = DONE;
               end
`else
               data_d = {fill, data_q[N-1:1]};
               cnt_d  = cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  state_d = DONE;
               end
`endif
            end
            DONE: begin
               if (result_ready_i) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
      end
   end

   assign ready_o        = (state_q == IDLE);
   assign result_valid_o = (state_q == DONE);
   assign busy_o         = (state_q != IDLE);
   assign result_o       = data_q;

endmodule

// File: tb/tb_shift_r_seq.sv
// Bench for shift_r_seq.
// The driver pushes the expected result and the expected result cycle when a
// request is accepted. The monitor pops and compares when result_valid_o
// rises, and checks that the result holds while backpressured.
module tb_shift_r_seq;
   localparam int N  = 32;
   localparam int SW = 5;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          valid_i;
   logic          ready_o;
   logic [N-1:0]  data_i;
   logic [SW-1:0] shamt_i;
   logic          arith_i;
   logic          flush_i;
   logic [N-1:0]  result_o;
   logic          result_valid_o;
   logic          result_ready_i;
   logic          busy_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int valid_seen = 0;

   logic [N-1:0] exp_q[$];
   int           exp_cyc_q[$];

   shift_r_seq #(.N(N), .SHAMT_W(SW)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .data_i         (data_i),
      .shamt_i        (shamt_i),
      .arith_i        (arith_i),
      .flush_i        (flush_i),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .busy_o         (busy_o)
   );

   // Clock and cycle counter
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference model: the shift operators applied to the whole value
   function automatic logic [N-1:0] ref_shift(logic [N-1:0] d, int sh, bit ar);
      logic signed [N-1:0] s;
      s = d;
      if (ar) return s >>> sh;
      return d >> sh;
   endfunction

   // Number of edges from accept to result_valid_o
   function automatic int ref_lat(int sh);
`ifdef SHIFT_R_RADIX2_EN
      return (sh + 1) / 2;
`else
      return sh;
`endif
   endfunction

   task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare on the rise of result_valid_o, then check stability
   logic         prev_v = 1'b0;
   logic [N-1:0] held   = '0;
   always @(negedge clk_i) begin
      if (rst_n_i && result_valid_o && !prev_v) begin
         valid_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%08h with empty queue", result_o);
         end else begin
            check("result", result_o, exp_q.pop_front());
            check("latency_cycle", N'(cyc), N'(exp_cyc_q.pop_front()));
         end
         held = result_o;
      end else if (rst_n_i && result_valid_o && prev_v) begin
         check("hold_result", result_o, held);
         check("hold_ready_low", {31'b0, ready_o}, '0);
      end
      prev_v = result_valid_o;
   end

   // Driver: issue one request, push expectation, then consume after 'hold'.
   // With junk set, valid_i is driven with garbage while the result waits.
   task automatic req(logic [N-1:0] d, int sh, bit ar, int hold, bit junk);
      int n;
      @(negedge clk_i);
      data_i  = d;
      shamt_i = SW'(sh);
      arith_i = ar;
      valid_i = 1'b1;
      n = 0;
      while (!ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: ready_o stuck at 0 expected 1");
      end
      @(posedge clk_i);
      #1;
      exp_q.push_back(ref_shift(d, sh, ar));
      exp_cyc_q.push_back(cyc + ref_lat(sh));
      // Inputs change after the accept edge and must be ignored
      valid_i = 1'b0;
      data_i  = $urandom;
      shamt_i = SW'($urandom_range(0, 31));
      arith_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check("busy_after_accept", {31'b0, busy_o}, 32'd1);
      check("ready_after_accept", {31'b0, ready_o}, '0);
      n = 0;
      while (!result_valid_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (!result_valid_o) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: result_valid_o stuck at 0 expected 1");
      end
      if (junk) valid_i = 1'b1;
      repeat (hold) @(negedge clk_i);
      @(negedge clk_i);
      result_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      result_ready_i = 1'b0;
      valid_i        = 1'b0;
      check("idle_after_consume", {31'b0, ready_o}, 32'd1);
      check("valid_after_consume", {31'b0, result_valid_o}, '0);
   endtask

   // Accept a request without expecting a result (it will be aborted)
   task automatic start_abort(logic [N-1:0] d, int sh, bit ar);
      @(negedge clk_i);
      data_i  = d;
      shamt_i = SW'(sh);
      arith_i = ar;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_result"}, result_o, '0);
      check({tag, "_valid"}, {31'b0, result_valid_o}, '0);
      check({tag, "_busy"}, {31'b0, busy_o}, '0);
      check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Main stimulus
   initial begin
      int vs;
      rst_n_i        = 1'b0;
      valid_i        = 1'b0;
      data_i         = '0;
      shamt_i        = '0;
      arith_i        = 1'b0;
      flush_i        = 1'b0;
      result_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset_outputs("reset");
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Directed cases
      req(32'h8000_0000, 4, 1'b0, 0, 1'b0);
      req(32'h8000_0000, 4, 1'b1, 1, 1'b0);
      req(32'h8000_0000, 31, 1'b1, 0, 1'b0);
      req(32'h8000_0000, 31, 1'b0, 0, 1'b0);
      req(32'h1234_5678, 0, 1'b0, 2, 1'b0);
      req(32'h7FFF_FFFF, 1, 1'b1, 0, 1'b0);
      // Backpressure for 10 cycles with a new request held on valid_i
      req(32'hC0DE_F00D, 7, 1'b1, 10, 1'b1);

      // Asynchronous reset in the middle of a shift
      start_abort(32'hDEAD_BEEF, 20, 1'b1);
      repeat (4) @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      #2;
      rst_n_i = 1'b1;
      vs = valid_seen;
      repeat (25) @(negedge clk_i);
      check("no_result_after_reset", N'(valid_seen), N'(vs));
      req(32'hA5A5_A5A5, 5, 1'b1, 0, 1'b0);

      // Flush in the middle of a shift
      start_abort(32'h0F0F_0F0F, 10, 1'b0);
      repeat (2) @(negedge clk_i);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      check("flush_ready", {31'b0, ready_o}, 32'd1);
      check("flush_busy", {31'b0, busy_o}, '0);
      vs = valid_seen;
      repeat (15) @(negedge clk_i);
      check("no_result_after_flush", N'(valid_seen), N'(vs));

      // Flush together with valid_i in IDLE: no accept
      @(negedge clk_i);
      valid_i = 1'b1;
      flush_i = 1'b1;
      data_i  = 32'h1111_1111;
      shamt_i = SW'(3);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      check("flush_idle_no_accept", {31'b0, ready_o}, 32'd1);
      check("flush_idle_busy", {31'b0, busy_o}, '0);
      req(32'h8765_4321, 3, 1'b1, 0, 1'b0);

      // Randomized requests
      for (int i = 0; i < 40; i++) begin
         req($urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk_i);
      check("queue_empty", N'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
